// File: rtl/mem_wb_if.sv
// mem_wb_if: MEM->WB bundle.
//   master (MEM/control side) drives mvalid, mwreg, mm2reg, mdest, malu, mdo, mldsz, mldsgn, stall, flush
//   slave (WB stage) drives wwreg, wmux_id_out, wmux_out, wretire
interface mem_wb_if;
    logic        mvalid;
    logic        mwreg;
    logic        mm2reg;
    logic [4:0]  mdest;
    logic [31:0] malu;
    logic [31:0] mdo;
    logic [1:0]  mldsz;
    logic        mldsgn;
    logic        stall;
    logic        flush;
    logic        wwreg;
    logic [4:0]  wmux_id_out;
    logic [31:0] wmux_out;
    logic [31:0] wretire;
    modport master (
        output mvalid, mwreg, mm2reg, mdest, malu, mdo, mldsz, mldsgn, stall, flush,
        input  wwreg, wmux_id_out, wmux_out, wretire
    );
    modport slave (
        input  mvalid, mwreg, mm2reg, mdest, malu, mdo, mldsz, mldsgn, stall, flush,
        output wwreg, wmux_id_out, wmux_out, wretire
    );
endinterface

// File: rtl/mem_wb_writer.sv
// mem_wb_writer: MEM/WB pipeline register with load extraction and retire counter.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_wb_if.slave (MEM inputs, stall/flush, register-file write port, retire count)
module mem_wb_writer (
    input logic      clk,
    input logic      rst,
    mem_wb_if.slave  bus
);
    typedef struct packed {
        logic        valid;
        logic        wreg;
        logic        m2reg;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] mdo;
        logic [1:0]  ldsz;
        logic        ldsgn;
    } wb_t;
    wb_t         wb_q, wb_d;
    logic [31:0] retire_q, retire_d;
    logic [15:0] half;
    logic [7:0]  byt;
    logic [31:0] ld;
    always_comb begin
        wb_d = bus.stall ? wb_q : bus.flush ? '0 :
               wb_t'({bus.mvalid, bus.mwreg, bus.mm2reg, bus.mdest, bus.malu, bus.mdo, bus.mldsz, bus.mldsgn});
        retire_d = retire_q + {31'd0, ~bus.stall & wb_q.valid};
        // big-endian lane selection from the registered address low bits
        half = wb_q.alu[1] ? wb_q.mdo[15:0] : wb_q.mdo[31:16];
        byt  = wb_q.alu[1] ? (wb_q.alu[0] ? wb_q.mdo[7:0] : wb_q.mdo[15:8])
                           : (wb_q.alu[0] ? wb_q.mdo[23:16] : wb_q.mdo[31:24]);
        ld   = wb_q.ldsz == 2'b01 ? {{16{wb_q.ldsgn & half[15]}}, half} :
               wb_q.ldsz == 2'b10 ? {{24{wb_q.ldsgn & byt[7]}}, byt} : wb_q.mdo;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q     <= '0;
            retire_q <= '0;
        end else begin
            wb_q     <= wb_d;
            retire_q <= retire_d;
        end
    end
    // a stalled instruction stays in WB, so its write is suppressed until release
    assign bus.wwreg       = wb_q.valid & wb_q.wreg & (wb_q.dest != 5'd0) & ~bus.stall;
    assign bus.wmux_id_out = wb_q.dest;
    assign bus.wmux_out    = wb_q.m2reg ? ld : wb_q.alu;
    assign bus.wretire     = retire_q;
endmodule

// File: tb/tb_mem_wb_writer.sv
// tb_mem_wb_writer: scoreboard bench with a behavioural model of the WB stage.
module tb_mem_wb_writer;
    logic clk = 0;
    logic rst;
    always #5 clk = ~clk;
    mem_wb_if bus ();
    mem_wb_writer dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic        w;
        logic [4:0]  id;
        logic [31:0] data;
        logic [31:0] ret;
    } exp_t;
    exp_t exp_q[$];
    int tests = 0, fails = 0;

    // model: the instruction sitting in WB, with its final write value already computed
    logic        m_valid, m_wreg;
    logic [4:0]  m_dest;
    logic [31:0] m_data, m_retire;

    function automatic logic [31:0] extract(logic [31:0] d, logic [31:0] a, logic [1:0] sz, logic sg);
        logic [31:0] v;
        if (sz == 2'b01) begin
            v = (d >> (16 * (1 - a[1]))) & 32'hFFFF;
            if (sg && v >= 32'h8000) v = v + 32'hFFFF0000;
        end else if (sz == 2'b10) begin
            v = (d >> (8 * (3 - a[1:0]))) & 32'hFF;
            if (sg && v >= 32'h80) v = v + 32'hFFFFFF00;
        end else v = d;
        return v;
    endfunction

    task automatic step(input logic r, input logic v, input logic w, input logic m2, input logic [4:0] d,
                        input logic [31:0] alu, input logic [31:0] dout, input logic [1:0] sz,
                        input logic sg, input logic st, input logic fl);
        exp_t e;
        rst = r; bus.mvalid = v; bus.mwreg = w; bus.mm2reg = m2; bus.mdest = d; bus.malu = alu;
        bus.mdo = dout; bus.mldsz = sz; bus.mldsgn = sg; bus.stall = st; bus.flush = fl;
        e.w = m_valid && m_wreg && m_dest != 0 && !st;
        e.id = m_dest; e.data = m_data; e.ret = m_retire;
        exp_q.push_back(e);
        if (r) begin
            m_valid = 0; m_wreg = 0; m_dest = 0; m_data = 0; m_retire = 0;
        end else if (!st) begin
            if (m_valid) m_retire = m_retire + 1;
            if (fl) begin
                m_valid = 0; m_wreg = 0; m_dest = 0; m_data = 0;
            end else begin
                m_valid = v; m_wreg = w; m_dest = d; m_data = m2 ? extract(dout, alu, sz, sg) : alu;
            end
        end
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            tests += 4;
            if (bus.wwreg !== e.w) begin fails++; $display("FAIL wwreg got %0b want %0b @%0t", bus.wwreg, e.w, $time); end
            if (bus.wmux_id_out !== e.id) begin fails++; $display("FAIL wmux_id_out got %0d want %0d @%0t", bus.wmux_id_out, e.id, $time); end
            if (bus.wmux_out !== e.data) begin fails++; $display("FAIL wmux_out got %h want %h @%0t", bus.wmux_out, e.data, $time); end
            if (bus.wretire !== e.ret) begin fails++; $display("FAIL wretire got %0d want %0d @%0t", bus.wretire, e.ret, $time); end
        end
    end

    initial begin
        rst = 1; bus.mvalid = 0; bus.mwreg = 0; bus.mm2reg = 0; bus.mdest = 0; bus.malu = 0;
        bus.mdo = 0; bus.mldsz = 0; bus.mldsgn = 0; bus.stall = 0; bus.flush = 0;
        m_valid = 0; m_wreg = 0; m_dest = 0; m_data = 0; m_retire = 0;
        @(posedge clk); #1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // ALU op, lb/lbu, lh/lhu, write to $0
        step(0, 1, 1, 0, 5, 32'h12345678, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 3, 32'h00001001, 32'h11F23344, 2'b10, 1, 0, 0);
        step(0, 1, 1, 1, 3, 32'h00001001, 32'h11F23344, 2'b10, 0, 0, 0);
        step(0, 1, 1, 1, 4, 32'h00000002, 32'hAAAA8001, 2'b01, 1, 0, 0);
        step(0, 1, 1, 1, 4, 32'h00000000, 32'hAAAA8001, 2'b01, 0, 0, 0);
        step(0, 1, 1, 1, 6, 32'h00000003, 32'h0102F3FE, 2'b11, 1, 0, 0);
        step(0, 1, 1, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        // stall 3 cycles with dest=7, flush+stall holds, then release
        step(0, 1, 1, 0, 7, 32'hCAFE0007, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 9, 32'h11111111, 0, 0, 0, 1, 0);
        step(0, 1, 1, 0, 9, 32'h11111111, 0, 0, 0, 1, 1);
        step(0, 1, 1, 0, 9, 32'h11111111, 0, 0, 0, 1, 0);
        step(0, 1, 1, 0, 9, 32'h22222222, 0, 0, 0, 0, 1);
        step(0, 1, 1, 0, 8, 32'h33333333, 0, 0, 0, 0, 0);
        // reset mid-stream with a valid write in WB, then capture right after
        step(1, 1, 1, 0, 10, 32'h44444444, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 11, 32'h55555555, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 1'($urandom), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom), $urandom, $urandom,
                 2'($urandom), 1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
        @(negedge clk); #1;
        tests++;
        if (exp_q.size() != 0) begin fails++; $display("FAIL drain got %0d pending want 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
